// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic intersection controller.
// Contents:
//   tlc_state_e   : controller phase (GREEN, YELLOW, ALL_RED)
//   STATUS_*      : 2-bit status encodings driven on the status output
//   state_status(): maps a phase to its status code, ignoring pending requests
package tlc_pkg;

    typedef enum logic [1:0] {
        GREEN   = 2'd0,
        YELLOW  = 2'd1,
        ALL_RED = 2'd2
    } tlc_state_e;

    localparam logic [1:0] STATUS_GO        = 2'b00;
    localparam logic [1:0] STATUS_STOP_PREP = 2'b01;
    localparam logic [1:0] STATUS_STOP      = 2'b10;
    localparam logic [1:0] STATUS_REQ       = 2'b11;

    function automatic logic [1:0] state_status(input tlc_state_e st);
        logic [1:0] s;
        unique case (st)
            GREEN:   s = STATUS_GO;
            YELLOW:  s = STATUS_STOP_PREP;
            default: s = STATUS_STOP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tlc_tick_gen.sv
// Free-running one-second tick generator.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   tick  : one-cycle pulse while the counter sits at TICK_DIV-1
module tlc_tick_gen #(
    parameter int unsigned TICK_DIV = 12000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Round-robin traffic light controller for NUM_WAYS approaches.
// Each way in turn gets GREEN -> YELLOW -> ALL_RED; durations are counted in ticks.
// Build option: define TLC_PED_REQ_EN to enable request buttons, which can cut a
// green phase short once MIN_GREEN_SEC has elapsed.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   button[NUM_WAYS]      : raw asynchronous request inputs
//   red/yellow/green      : registered per-way lamp drives
//   active_way            : index of the way currently served
//   status                : 00 go, 01 prepare-to-stop, 10 stop, 11 request pending
//   status_strobe         : one-cycle pulse whenever status changes
module traffic_intersection_ctrl
    import tlc_pkg::*;
#(
    parameter int unsigned NUM_WAYS      = 2,
    parameter int unsigned TICK_DIV      = 12000000,
    parameter int unsigned GREEN_SEC     = 4,
    parameter int unsigned MIN_GREEN_SEC = 2,
    parameter int unsigned YELLOW_SEC    = 2,
    parameter int unsigned ALLRED_SEC    = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_WAYS-1:0]         button,
    output logic [NUM_WAYS-1:0]         red,
    output logic [NUM_WAYS-1:0]         yellow,
    output logic [NUM_WAYS-1:0]         green,
    output logic [$clog2(NUM_WAYS)-1:0] active_way,
    output logic [1:0]                  status,
    output logic                        status_strobe
);

    localparam int unsigned AW = $clog2(NUM_WAYS);

    tlc_state_e          state_q, state_d;
    logic [AW-1:0]       way_q, way_d, next_way;
    logic [7:0]          sec_q, sec_d;
    logic                tick;
    logic                req_cut;
    logic [NUM_WAYS-1:0] way_mask;
    logic [NUM_WAYS-1:0] pending;
    logic [NUM_WAYS-1:0] red_d, yellow_d, green_d;
    logic [1:0]          status_d;

    tlc_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign way_mask = NUM_WAYS'(1) << way_q;
    assign next_way = (way_q == AW'(NUM_WAYS - 1)) ? '0 : way_q + AW'(1);
    // Only requests from other ways may shorten the current green.
    assign req_cut  = (|(pending & ~way_mask)) && (sec_q >= 8'(MIN_GREEN_SEC - 1));

    always_comb begin
        state_d = state_q;
        way_d   = way_q;
        sec_d   = sec_q;
        if (tick) begin
            sec_d = sec_q + 8'd1;
            unique case (state_q)
                GREEN: begin
                    if (sec_q == 8'(GREEN_SEC - 1) || req_cut) begin
                        state_d = YELLOW;
                        sec_d   = '0;
                    end
                end
                YELLOW: begin
                    if (sec_q == 8'(YELLOW_SEC - 1)) begin
                        state_d = ALL_RED;
                        sec_d   = '0;
                    end
                end
                ALL_RED: begin
                    if (sec_q == 8'(ALLRED_SEC - 1)) begin
                        state_d = GREEN;
                        way_d   = next_way;
                        sec_d   = '0;
                    end
                end
                default: begin
                    state_d = ALL_RED;
                    sec_d   = '0;
                end
            endcase
        end
    end

    // Lamps and status are decoded from the current state and registered,
    // so they follow the state by one cycle.
    always_comb begin
        red_d    = '1;
        yellow_d = '0;
        green_d  = '0;
        unique case (state_q)
            GREEN: begin
                green_d = way_mask;
                red_d   = ~way_mask;
            end
            YELLOW: begin
                yellow_d = way_mask;
                red_d    = ~way_mask;
            end
            default: ;
        endcase
        status_d = ((state_q == GREEN) && (|pending)) ? STATUS_REQ : state_status(state_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ALL_RED;
            way_q         <= AW'(NUM_WAYS - 1);
            sec_q         <= '0;
            red           <= '1;
            yellow        <= '0;
            green         <= '0;
            status        <= STATUS_STOP;
            status_strobe <= 1'b0;
        end else begin
            state_q       <= state_d;
            way_q         <= way_d;
            sec_q         <= sec_d;
            red           <= red_d;
            yellow        <= yellow_d;
            green         <= green_d;
            status        <= status_d;
            status_strobe <= (status_d != status);
        end
    end

    assign active_way = way_q;

`ifdef TLC_PED_REQ_EN
    logic [NUM_WAYS-1:0] sync1_q, sync2_q, prev_q, pending_q, pending_d;
    logic [NUM_WAYS-1:0] rise, next_mask;
    logic                enter_green;

    assign next_mask   = NUM_WAYS'(1) << next_way;
    assign enter_green = tick && (state_q == ALL_RED) && (sec_q == 8'(ALLRED_SEC - 1));

    always_comb begin
        rise      = sync2_q & ~prev_q;
        pending_d = pending_q | rise;
        // The way being served never holds a request; an edge landing on the
        // entry cycle is dropped with it.
        if (state_q == GREEN) begin
            pending_d = pending_d & ~way_mask;
        end
        if (enter_green) begin
            pending_d = pending_d & ~next_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            pending_q <= '0;
        end else begin
            sync1_q   <= button;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
`else
    logic unused_button;
    assign unused_button = ^button;
    assign pending       = '0;
`endif

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Scoreboard bench for traffic_intersection_ctrl: a 2-way and a 4-way instance run
// side by side. Stimulus pushes the expected output events (cycle since reset
// release, lamps, status, active way, strobe); a monitor pops one record each
// time the lamps or status of an instance change and compares.
module tb_traffic_intersection_ctrl;

    localparam int K_G = 0;
    localparam int K_Y = 1;
    localparam int K_A = 2;

    typedef struct {
        int          since;
        logic [28:0] obs;
        logic        stb;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] btn2;
    logic [3:0] btn4;
    logic [1:0] red2, yellow2, green2, status2;
    logic [0:0] active2;
    logic       strobe2;
    logic [3:0] red4, yellow4, green4;
    logic [1:0] status4, active4;
    logic       strobe4;

    exp_t exp2_q[$];
    exp_t exp4_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   since    = 0;
    int   pos      = 0;
    logic [28:0] prev2 = 'x;
    logic [28:0] prev4 = 'x;

    always #5 clk = ~clk;

    traffic_intersection_ctrl #(
        .NUM_WAYS(2), .TICK_DIV(4), .GREEN_SEC(4), .MIN_GREEN_SEC(2),
        .YELLOW_SEC(2), .ALLRED_SEC(1)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .button(btn2), .red(red2), .yellow(yellow2),
        .green(green2), .active_way(active2), .status(status2), .status_strobe(strobe2)
    );

    traffic_intersection_ctrl #(
        .NUM_WAYS(4), .TICK_DIV(4), .GREEN_SEC(4), .MIN_GREEN_SEC(2),
        .YELLOW_SEC(2), .ALLRED_SEC(1)
    ) u_dut4 (
        .clk(clk), .rst_n(rst_n), .button(btn4), .red(red4), .yellow(yellow4),
        .green(green4), .active_way(active4), .status(status4), .status_strobe(strobe4)
    );

    // Queue one expected event; lamp masks are built from the phase and way.
    task automatic ev(input int dut, input int k, input int kind, input int way,
                      input logic [1:0] st, input logic stb);
        exp_t       e;
        logic [7:0] nmask, wbit, r, y, g;
        nmask = (dut == 2) ? 8'h03 : 8'h0F;
        wbit  = 8'(1) << way;
        r = nmask;
        y = 8'h00;
        g = 8'h00;
        if (kind == K_G) begin
            g = wbit;
            r = nmask & ~wbit;
        end else if (kind == K_Y) begin
            y = wbit;
            r = nmask & ~wbit;
        end
        e.since = k;
        e.obs   = {st, 3'(way), r, y, g};
        e.stb   = stb;
        if (dut == 2) exp2_q.push_back(e);
        else exp4_q.push_back(e);
    endtask

    task automatic check_evt(input int dut, input logic [28:0] obs, input logic stb);
        exp_t e;
        int   n;
        n = (dut == 2) ? exp2_q.size() : exp4_q.size();
        checks++;
        if (n == 0) begin
            failures++;
            $display("FAIL unexpected_event dut%0d: got k=%0d obs=%h, required no event",
                     dut, since, obs);
        end else begin
            e = (dut == 2) ? exp2_q.pop_front() : exp4_q.pop_front();
            if (e.since != since || e.obs !== obs || e.stb !== stb) begin
                failures++;
                $display("FAIL event dut%0d: got k=%0d obs=%h strobe=%b, required k=%0d obs=%h strobe=%b",
                         dut, since, obs, stb, e.since, e.obs, e.stb);
            end
        end
    endtask

    task automatic check_quiet(input int dut, input logic stb);
        checks++;
        if (stb !== 1'b0) begin
            failures++;
            $display("FAIL strobe_idle dut%0d: got strobe=%b at k=%0d, required 0", dut, stb, since);
        end
    endtask

    // Monitor: an event is any change of lamps or status; active_way is compared
    // with the event but does not trigger one on its own.
    always @(negedge clk) begin
        logic [28:0] o2, o4;
        if (!rst_n) since = 0;
        else since++;
        o2 = {status2, 3'(active2), 8'(red2), 8'(yellow2), 8'(green2)};
        o4 = {status4, 3'(active4), 8'(red4), 8'(yellow4), 8'(green4)};
        if ((o2 & ~29'h07000000) !== (prev2 & ~29'h07000000)) check_evt(2, o2, strobe2);
        else check_quiet(2, strobe2);
        if ((o4 & ~29'h07000000) !== (prev4 & ~29'h07000000)) check_evt(4, o4, strobe4);
        else check_quiet(4, strobe4);
        prev2 = o2;
        prev4 = o4;
    end

    // Advance to just after the k-th falling edge since reset release.
    task automatic go(input int k);
        repeat (k - pos) @(negedge clk);
        #1;
        pos = k;
    endtask

    initial begin
        rst_n = 1'b1;
        btn2  = '0;
        btn4  = '0;
        ev(2, 0, K_A, 1, 2'b10, 1'b0);
        ev(4, 0, K_A, 3, 2'b10, 1'b0);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        pos = 0;

        // Free-running cycle, then reset in the middle of way1's yellow.
        for (int d = 2; d <= 4; d += 2) begin
            ev(d, 5,  K_G, 0, 2'b00, 1'b1);
            ev(d, 21, K_Y, 0, 2'b01, 1'b1);
            ev(d, 29, K_A, 0, 2'b10, 1'b1);
            ev(d, 33, K_G, 1, 2'b00, 1'b1);
            ev(d, 49, K_Y, 1, 2'b01, 1'b1);
            ev(d, 0,  K_A, d - 1, 2'b10, 1'b0);
        end
        go(52);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        pos = 0;

        // Requests: dut2 way1 early in way0 green, then way1 during its own green;
        // dut4 ways 1 and 3 together.
`ifdef TLC_PED_REQ_EN
        ev(2, 5,  K_G, 0, 2'b00, 1'b1);
        ev(2, 9,  K_G, 0, 2'b11, 1'b1);
        ev(2, 13, K_Y, 0, 2'b01, 1'b1);
        ev(2, 21, K_A, 0, 2'b10, 1'b1);
        ev(2, 25, K_G, 1, 2'b00, 1'b1);
        ev(2, 41, K_Y, 1, 2'b01, 1'b1);
        ev(2, 49, K_A, 1, 2'b10, 1'b1);
        ev(2, 53, K_G, 0, 2'b00, 1'b1);
        ev(2, 69, K_Y, 0, 2'b01, 1'b1);
        ev(4, 5,  K_G, 0, 2'b00, 1'b1);
        ev(4, 9,  K_G, 0, 2'b11, 1'b1);
        ev(4, 13, K_Y, 0, 2'b01, 1'b1);
        ev(4, 21, K_A, 0, 2'b10, 1'b1);
        ev(4, 25, K_G, 1, 2'b11, 1'b1);
        ev(4, 33, K_Y, 1, 2'b01, 1'b1);
        ev(4, 41, K_A, 1, 2'b10, 1'b1);
        ev(4, 45, K_G, 2, 2'b11, 1'b1);
        ev(4, 53, K_Y, 2, 2'b01, 1'b1);
        ev(4, 61, K_A, 2, 2'b10, 1'b1);
        ev(4, 65, K_G, 3, 2'b00, 1'b1);
`else
        for (int d = 2; d <= 4; d += 2) begin
            ev(d, 5,  K_G, 0, 2'b00, 1'b1);
            ev(d, 21, K_Y, 0, 2'b01, 1'b1);
            ev(d, 29, K_A, 0, 2'b10, 1'b1);
            ev(d, 33, K_G, 1, 2'b00, 1'b1);
            ev(d, 49, K_Y, 1, 2'b01, 1'b1);
            ev(d, 57, K_A, 1, 2'b10, 1'b1);
            ev(d, 61, K_G, (d == 2) ? 0 : 2, 2'b00, 1'b1);
        end
`endif
        go(5);
        btn2 = 2'b10;
        btn4 = 4'b1010;
        go(8);
        btn2 = '0;
        btn4 = '0;
        go(27);
        btn2 = 2'b10;
        go(30);
        btn2 = '0;
        go(72);

        checks++;
        if (exp2_q.size() != 0) begin
            failures++;
            $display("FAIL missing_events dut2: got %0d events outstanding, required 0",
                     exp2_q.size());
        end
        checks++;
        if (exp4_q.size() != 0) begin
            failures++;
            $display("FAIL missing_events dut4: got %0d events outstanding, required 0",
                     exp4_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_intersection_ctrl.md
TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

Interface
REQ-001 Parameter NUM_WAYS, default 2: number of approaches; legal range 2..8.
REQ-002 Parameter TICK_DIV, default 12000000: clk cycles per one-second tick; legal minimum 2.
REQ-003 Parameter GREEN_SEC, default 4: full green duration in ticks; legal range 1..255.
REQ-004 Parameter MIN_GREEN_SEC, default 2: green duration before a pending request may cut green short; legal range 1..GREEN_SEC.
REQ-005 Parameters YELLOW_SEC, default 2, and ALLRED_SEC, default 1: yellow and all-red durations in ticks; legal range 1..255.
REQ-006 clk  in  1  sole clock; every register is clocked on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 button  in  NUM_WAYS  raw, asynchronous request inputs, one per way.
REQ-009 red, yellow, green  out  NUM_WAYS each  per-way lamp drives, all registered.
REQ-010 active_way  out  clog2(NUM_WAYS)  index of the way currently served.
REQ-011 status  out  2  00 go, 01 prepare-to-stop, 10 full stop, 11 request pending.
REQ-012 status_strobe  out  1  one-cycle pulse on every status change.

Function
REQ-013 Tick generator: counter runs 0..TICK_DIV-1 and wraps; tick pulses for one cycle when the counter equals TICK_DIV-1.
REQ-014 FSM states are GREEN, YELLOW and ALL_RED; an 8-bit second counter increments on each tick and clears on every state entry.
REQ-015 GREEN -> YELLOW on the tick at which the second counter reaches GREEN_SEC-1, or earlier per REQ-019.
REQ-016 YELLOW -> ALL_RED on the tick at which the second counter reaches YELLOW_SEC-1.
REQ-017 ALL_RED -> GREEN on the tick at which the second counter reaches ALLRED_SEC-1; at the same time active_way advances by 1 and wraps from NUM_WAYS-1 to 0.
REQ-018 Lamps: active_way shows green in GREEN and yellow in YELLOW; every other way shows red; all ways show red in ALL_RED; lamps lag the state by exactly one cycle.
REQ-019 Early end of green: if a request is pending for any non-active way and the second counter is >= MIN_GREEN_SEC-1, GREEN ends at the next tick.
REQ-020 Request capture: button is passed through a 2-flop synchroniser; a rising edge sets pending[i]; multiple simultaneous edges each set their own bit.
REQ-021 A request for the active way while it is in GREEN is discarded; pending[i] clears on the cycle way i enters GREEN.
REQ-022 Status is 11 while any pending bit is set and the state is GREEN; otherwise it maps GREEN/YELLOW/ALL_RED to 00/01/10.
REQ-023 A request edge on the same cycle as its way enters GREEN is discarded.
REQ-024 The tick counter is free-running; state changes do not reset it.

Reset
REQ-025 On rst_n low: state ALL_RED, active_way NUM_WAYS-1, both counters 0, pending all 0, synchroniser flops 0.
REQ-026 During reset: red all 1, yellow and green all 0, status 10, status_strobe 0.
REQ-027 Reset asserted mid-state aborts immediately; after release, way 0 is the first to get GREEN, after ALLRED_SEC ticks.

Configuration
REQ-028 Macro TLC_PED_REQ_EN defined: REQ-019..REQ-023 apply.
REQ-029 Macro TLC_PED_REQ_EN absent: the button port remains, pending stays 0, no synchroniser is built, status 11 never occurs, and green always lasts GREEN_SEC.

Structure
REQ-030 Package tlc_pkg shall hold the state enum (GREEN, YELLOW, ALL_RED) and the STATUS_GO/STOP_PREP/STOP/REQ 2-bit constants.
REQ-031 The tick generator shall be sub-module tlc_tick_gen, parameterised by TICK_DIV, with outputs tick and a one-cycle pulse.

Verification (TICK_DIV=4, GREEN_SEC=4, MIN_GREEN_SEC=2, YELLOW_SEC=2, ALLRED_SEC=1)
REQ-032 No buttons, NUM_WAYS=2 -> way0 green 16 cycles, yellow 8, all-red 4, then way1 green; sequence repeats with a 56-cycle period.
REQ-033 Pulse button[1] for 3 cycles at green tick 0 -> status 11 with strobe; way0 green ends after 2 ticks (8 cycles) instead of 4.
REQ-034 button[0] edge while way0 is GREEN -> pending[0] stays 0, status stays 00, full-length green.
REQ-035 NUM_WAYS=4, buttons 1 and 3 in the same cycle -> both pending; cleared in turn as way1 and then way3 reach GREEN.
REQ-036 rst_n low during YELLOW of way1 -> all lamps red in the same cycle, status 10; after release, way0 green after 4 cycles.
REQ-037 Build without TLC_PED_REQ_EN, run the REQ-033 stimulus -> timing identical to REQ-032, status never 11.
